// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo sample FIFO feeding the I2S serializer, popped once per lrclk frame
module audio_sample_fifo #(
    parameter int AUDIO_DW    = 16,
    parameter int DEPTH_LOG2  = 3,
    parameter int UNSIGNED_IN = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_strobe,
    input  logic [AUDIO_DW-1:0]   in_left,
    input  logic [AUDIO_DW-1:0]   in_right,
    input  logic                  lrclk,
    output logic [AUDIO_DW-1:0]   out_left,
    output logic [AUDIO_DW-1:0]   out_right,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic                  overflow,
    input  logic                  clr_flags
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [2*AUDIO_DW-1:0] mem_q [DEPTH];

    logic                  lrclk_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [AUDIO_DW-1:0]   out_l_q, out_l_d;
    logic [AUDIO_DW-1:0]   out_r_q, out_r_d;
    logic                  und_q, und_d;
    logic                  ovf_q, ovf_d;
    logic                  pop_ev, pop_ok, push_ok, empty, full;

    function automatic logic [AUDIO_DW-1:0] conv(input logic [AUDIO_DW-1:0] x);
        if (UNSIGNED_IN != 0)
            conv = {~x[AUDIO_DW-1], x[AUDIO_DW-2:0]};
        else
            conv = x;
    endfunction

    // Push and pop both judge the pre-cycle level; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop_ev   = ~lrclk_q & lrclk;
        empty    = (level_q == '0);
        full     = (level_q == FULL);
        pop_ok   = pop_ev & ~empty;
        push_ok  = in_strobe & (~full | pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;

        if (push_ok)
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            {out_l_d, out_r_d} = mem_q[rd_ptr_q];
        end
        if (push_ok && !pop_ok)
            level_d = level_q + (DEPTH_LOG2+1)'(1);
        else if (pop_ok && !push_ok)
            level_d = level_q - (DEPTH_LOG2+1)'(1);

        und_d = (und_q & ~clr_flags) | (pop_ev & empty);
        ovf_d = (ovf_q & ~clr_flags) | (in_strobe & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {conv(in_left), conv(in_right)};
    end

    // lrclk_q resets high to match the serializer, so leaving reset never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lrclk_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
            und_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            lrclk_q  <= lrclk;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            und_q    <= und_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_left  = out_l_q;
    assign out_right = out_r_q;
    assign level     = level_q;
    assign underrun  = und_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - self-checking bench for audio_sample_fifo (depth 4, signed and offset-binary instances)
module tb_audio_sample_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_strobe = 1'b0;
    logic [15:0] in_left = '0, in_right = '0;
    logic        lrclk = 1'b1;
    logic        clr_flags = 1'b0;

    logic [15:0] a_out_l, a_out_r, b_out_l, b_out_r;
    logic [2:0]  a_level, b_level;
    logic        a_und, a_ovf, b_und, b_ovf;

    always #5 clk = ~clk;

    audio_sample_fifo #(.AUDIO_DW(16), .DEPTH_LOG2(2), .UNSIGNED_IN(0)) u_a (
        .clk(clk), .reset_n(reset_n), .in_strobe(in_strobe), .in_left(in_left),
        .in_right(in_right), .lrclk(lrclk), .out_left(a_out_l), .out_right(a_out_r),
        .level(a_level), .underrun(a_und), .overflow(a_ovf), .clr_flags(clr_flags));

    audio_sample_fifo #(.AUDIO_DW(16), .DEPTH_LOG2(2), .UNSIGNED_IN(1)) u_b (
        .clk(clk), .reset_n(reset_n), .in_strobe(in_strobe), .in_left(in_left),
        .in_right(in_right), .lrclk(lrclk), .out_left(b_out_l), .out_right(b_out_r),
        .level(b_level), .underrun(b_und), .overflow(b_ovf), .clr_flags(clr_flags));

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] m_out;
    logic        m_und, m_ovf, m_prev;

    typedef struct {
        logic        s;
        logic [15:0] l;
        logic        lr;
        logic        c;
        int          lvl;
        logic [15:0] out_l;
        logic        und;
        logic        ovf;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cv(input logic [15:0] x);
        cv = {~x[15], x[14:0]};
    endfunction

    task automatic check_all();
        chk("a_level", 32'(a_level), 32'(mq.size()));
        chk("a_out_l", 32'(a_out_l), 32'(m_out[31:16]));
        chk("a_out_r", 32'(a_out_r), 32'(m_out[15:0]));
        chk("a_und", 32'(a_und), 32'(m_und));
        chk("a_ovf", 32'(a_ovf), 32'(m_ovf));
        chk("b_out_l", 32'(b_out_l), 32'(m_out == 32'h0 ? 16'h0 : cv(m_out[31:16])));
        chk("b_out_r", 32'(b_out_r), 32'(m_out == 32'h0 ? 16'h0 : cv(m_out[15:0])));
        chk("b_level", 32'(b_level), 32'(mq.size()));
    endtask

    task automatic step(input logic s, input logic [15:0] l, input logic [15:0] r,
                        input logic lr, input logic c);
        logic pe, pop_ok, push_ok;
        int   sz;
        @(negedge clk);
        in_strobe = s; in_left = l; in_right = r; lrclk = lr; clr_flags = c;
        pe      = lr && !m_prev;
        sz      = mq.size();
        pop_ok  = pe && (sz > 0);
        push_ok = s && ((sz < 4) || pop_ok);
        if (pop_ok) m_out = mq.pop_front();
        if (push_ok) mq.push_back({l, r});
        m_und  = (m_und && !c) || (pe && sz == 0);
        m_ovf  = (m_ovf && !c) || (s && !push_ok);
        m_prev = lr;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic lr);
        @(negedge clk);
        reset_n = 1'b0; in_strobe = 1'b0; clr_flags = 1'b0; lrclk = lr;
        mq.delete();
        m_out = '0; m_und = 1'b0; m_ovf = 1'b0; m_prev = 1'b1;
        @(posedge clk);
        #1;
        check_all();
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_out_l", 32'(a_out_l), 32'd0);
        chk("rst_flags", {30'd0, a_und, a_ovf}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 2, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 3, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 4, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 4, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0001, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0001, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0002, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 2, 16'h0002, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0003, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1, 16'h0003, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0004, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0004, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0004, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0004, 1'b0, 1'b0};

        m_out = '0; m_und = 1'b0; m_ovf = 1'b0; m_prev = 1'b1;

        // Idle after reset: four frames with no strobes.
        do_reset(1'b1);
        for (int f = 0; f < 4; f++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            if (f == 0) chk("idle_und_first_rise", 32'(a_und), 32'd1);
            step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        chk("idle_out", {a_out_l, a_out_r}, 32'd0);
        chk("idle_ovf", 32'(a_ovf), 32'd0);

        // Single pair, one pop: visible one clock after lrclk rises, stable across the fall.
        do_reset(1'b1);
        step(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        chk("one_level1", 32'(a_level), 32'd1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("one_out", {a_out_l, a_out_r}, 32'h1234ABCD);
        chk("one_level0", 32'(a_level), 32'd0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("one_hold_fall", {a_out_l, a_out_r}, 32'h1234ABCD);

        // Overflow then drain to underrun, then clr_flags.
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].s, tbl[i].l, tbl[i].l + 16'h0100, tbl[i].lr, tbl[i].c);
            chk($sformatf("tbl%0d_level", i), 32'(a_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_out_l", i), 32'(a_out_l), 32'(tbl[i].out_l));
            chk($sformatf("tbl%0d_und", i), 32'(a_und), 32'(tbl[i].und));
            chk($sformatf("tbl%0d_ovf", i), 32'(a_ovf), 32'(tbl[i].ovf));
        end

        // Push coincident with pop while full, then while empty.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(16'h0010 + i), 16'(16'h0020 + i), 1'b0, 1'b0);
        step(1'b1, 16'h0055, 16'h0066, 1'b1, 1'b0);
        chk("full_co_level", 32'(a_level), 32'd4);
        chk("full_co_ovf", 32'(a_ovf), 32'd0);
        chk("full_co_out", 32'(a_out_l), 32'h0010);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        chk("full_co_last", {a_out_l, a_out_r}, 32'h00550066);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0077, 16'h0088, 1'b1, 1'b0);
        chk("empty_co_und", 32'(a_und), 32'd1);
        chk("empty_co_level", 32'(a_level), 32'd1);
        chk("empty_co_held", {a_out_l, a_out_r}, 32'h00550066);

        // Offset-binary conversion on instance b.
        do_reset(1'b1);
        step(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("unsigned_l", 32'(b_out_l), 32'h0000);
        chk("unsigned_r", 32'(b_out_r), 32'h8000);
        chk("signed_pass", {a_out_l, a_out_r}, 32'h80000000);

        // Mid-stream reset with level 3 and both flags set, lrclk held high.
        do_reset(1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'(16'h0A00 + i), 16'(16'h0B00 + i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(a_level), 32'd3);
        chk("pre_rst_flags", {30'd0, a_und, a_ovf}, 32'd3);
        do_reset(1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_no_pop", 32'(a_und), 32'd0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("clr_vs_set_und", 32'(a_und), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
Name:
audio_sample_fifo

Overview:
- Stereo sample buffer directly upstream of the I2S serializer.
- Accepts left/right sample pairs from the core on a per-sample strobe at the core's own audio rate. Presents one stable pair on out_left/out_right, which feed the serializer's left_chan/right_chan inputs.
- Advances one entry per I2S frame, timed from the serializer's lrclk. Absorbs core/I2S rate jitter, handles underrun/overflow deterministically, and optionally converts offset-binary input to two's complement.

Parameters:
- AUDIO_DW, 16, sample width per channel; must equal the serializer's AUDIO_DW.
- DEPTH_LOG2, 3, log2 of FIFO depth in stereo pairs (default depth 8); legal range 1..6.
- UNSIGNED_IN, 0, 1 = inputs are offset-binary, so MSB of each channel is inverted on write; 0 = two's complement, passed unchanged.

Ports:
- clk, input, 1, system clock; same clock as the serializer.
- reset_n, input, 1, synchronous active-low reset.
- in_strobe, input, 1, one-cycle pulse: push in_left/in_right.
- in_left, input, AUDIO_DW, left sample from core.
- in_right, input, AUDIO_DW, right sample from core.
- lrclk, input, 1, word-select output of the serializer.
- out_left, output, AUDIO_DW, registered left sample to serializer.
- out_right, output, AUDIO_DW, registered right sample to serializer.
- level, output, DEPTH_LOG2+1, current occupancy in pairs (0..2**DEPTH_LOG2).
- underrun, output, 1, sticky: a pop found the FIFO empty.
- overflow, output, 1, sticky: a push was dropped because the FIFO was full.
- clr_flags, input, 1, one-cycle pulse: clears underrun and overflow.

Behaviour:
- Storage: 2**DEPTH_LOG2 entries of 2*AUDIO_DW bits; binary write/read pointers of DEPTH_LOG2 bits wrap modulo depth; level is a separate counter.
- Reset (reset_n low at posedge clk), all take effect next edge and apply mid-operation too:
  - pointers=0, level=0, out_left=out_right=0, underrun=overflow=0;
  - lrclk_d=1, matching the serializer's reset lrclk=1 so no false edge is seen;
  - stored contents are don't-care.
- Pop event: lrclk_d==0 && lrclk==1, where lrclk_d is lrclk registered once.
  - This is the rising edge, the start of the right half-frame.
  - The serializer latches its inputs at the falling edge, so out_* is stable for at least half a frame beforehand.
- Pop when level>0:
  - out_left/out_right <= entry at the read pointer on the same edge the event is detected, so out_* updates 1 clk after lrclk rises;
  - read pointer +1; level -1.
- Pop when level==0:
  - out_* hold their previous value (last-sample repeat, no click);
  - underrun <= 1; pointers and level unchanged.
- Push event: in_strobe==1.
  - level < depth: write {conv(in_left), conv(in_right)} at the write pointer; write pointer +1; level +1.
  - level == depth: sample dropped; overflow <= 1; nothing else changes.
- conv(x): UNSIGNED_IN=1 gives {~x[MSB], x[MSB-1:0]}; otherwise x.
- Simultaneous push and pop in the same cycle: both are evaluated on the pre-cycle level.
  - level 1..depth-1: both succeed, level unchanged.
  - level==0: pop underruns and holds out_*; push is stored; level becomes 1. There is no write-to-read bypass.
  - level==depth: pop succeeds and push is accepted (slot freed this cycle); level unchanged; no overflow.
- Flag priority: clr_flags clears both flags, but a set condition in the same cycle wins (flag ends at 1).
- No combinational path from any input to any output; all outputs are registers.
- Latency: a push into an empty FIFO appears on out_* 1 clk after the next pop event.

Test Plan:
- Reset then idle, DEPTH_LOG2=2: toggle lrclk 4 frames, no strobes -> out_*=0 throughout, level=0, underrun=1 after the first lrclk rise, overflow=0.
- Push L=0x1234/R=0xABCD, then one lrclk rise -> out_left=0x1234, out_right=0xABCD exactly 1 clk after the rise; level 1->0; out_* unchanged at the following lrclk fall.
- Push 5 pairs (0x0001..0x0005) with no pops, depth 4 -> level=4, overflow=1; subsequent pops yield 1,2,3,4, then 4 repeats with underrun=1.
- Fill to 4, then in_strobe coincident with the pop-event cycle -> level stays 4, overflow=0, new sample read out last. Empty FIFO with coincident push+pop -> underrun=1, level=1, out_* held.
- UNSIGNED_IN=1: push 0x8000/0x0000 -> out_left=0x0000, out_right=0x8000.
- Mid-stream reset_n low for 1 clk with level=3 and flags set -> next cycle level=0, out_*=0, flags=0. lrclk held high across the reset produces no pop. clr_flags in the same cycle as a new underrun leaves underrun=1.
